sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes controller commands, tracks per-bank state and
// ACTIVE-to-access timing, and serves bursts from an internal 16-bit word store.
module sdram_responder #(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned TRCD   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_valid,
    output logic        cmd_err,
    output logic        err_sticky
);

    localparam int unsigned DEPTH   = 2 ** MEM_AW;
    localparam int unsigned CNT_W   = (TRCD > 2) ? $clog2(TRCD) : 1;
    localparam int unsigned TRCD_M1 = (TRCD > 0) ? TRCD - 1 : 0;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_BST,
        CMD_PRE,
        CMD_REF,
        CMD_LMR
    } cmd_e;

    // Column of burst beat k: sequential wrap inside the aligned burst block.
    function automatic logic [8:0] beat_col(input logic [8:0] base, input logic [2:0] k,
                                            input logic [2:0] mask);
        logic [8:0] m;
        m = {6'd0, mask};
        return (base & ~m) | ((base + {6'd0, k}) & m);
    endfunction

    logic [15:0]       mem_q [DEPTH];

    logic [3:0]        bank_act_q, bank_act_d;
    logic [12:0]       row_q [4];
    logic [12:0]       row_d [4];
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];

    logic              mode_valid_q, mode_valid_d;
    logic [2:0]        cl_q, cl_d;
    logic [2:0]        bl_q, bl_d;

    logic              gen_act_q, gen_act_d;
    logic [1:0]        gen_ba_q, gen_ba_d;
    logic [12:0]       gen_row_q, gen_row_d;
    logic [8:0]        gen_col_q, gen_col_d;
    logic [2:0]        gen_k_q, gen_k_d;
    logic [2:0]        gen_mask_q, gen_mask_d;
    logic              gen_cl3_q, gen_cl3_d;

    logic              p1_v_q, p1_v_d;
    logic [MEM_AW-1:0] p1_addr_q, p1_addr_d;
    logic              p1_cl3_q, p1_cl3_d;
    logic              p2_v_q, p2_v_d;
    logic [MEM_AW-1:0] p2_addr_q, p2_addr_d;

    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              cmd_err_q, cmd_err_d;
    logic              err_sticky_q, err_sticky_d;

    cmd_e              cmd;
    logic              acc_ok;
    logic [MEM_AW-1:0] acc_addr;
    logic [15:0]       cur_word;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic              cancel;
    logic              err;
    logic              mode_ok;
    logic [2:0]        bl_mask;
    logic              out_v;
    logic [MEM_AW-1:0] out_addr;
    logic [15:0]       fetch_data;

    // Command decode; INHIBIT and unlisted encodings act as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (!SDRAM_nCS) begin
            case ({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b110:  cmd = CMD_BST;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_LMR;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    always_comb begin
        bank_act_d   = bank_act_q;
        row_d        = row_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
        end
        mode_valid_d = mode_valid_q;
        cl_d         = cl_q;
        bl_d         = bl_q;
        gen_act_d    = gen_act_q;
        gen_ba_d     = gen_ba_q;
        gen_row_d    = gen_row_q;
        gen_col_d    = gen_col_q;
        gen_k_d      = gen_k_q;
        gen_mask_d   = gen_mask_q;
        gen_cl3_d    = gen_cl3_q;
        p2_v_d       = p1_v_q && p1_cl3_q;
        p2_addr_d    = p1_addr_q;
        p1_v_d       = 1'b0;
        p1_addr_d    = p1_addr_q;
        p1_cl3_d     = p1_cl3_q;
        mem_we       = 1'b0;
        cancel       = 1'b0;
        err          = 1'b0;

        acc_ok    = mode_valid_q && bank_act_q[SDRAM_BA] && (cnt_q[SDRAM_BA] == '0);
        acc_addr  = MEM_AW'({SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[8:0]});
        cur_word  = mem_q[acc_addr];
        mem_wdata = {SDRAM_DQMH ? cur_word[15:8] : dq_in[15:8],
                     SDRAM_DQML ? cur_word[7:0]  : dq_in[7:0]};
        bl_mask   = 3'((8'd1 << bl_q) - 8'd1);
        mode_ok   = ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) && !SDRAM_A[2]
                    && (SDRAM_A[9] || (SDRAM_A[2:0] == 3'd0));

        case (cmd)
            CMD_ACT: begin
                if (bank_act_q[SDRAM_BA]) begin
                    err = 1'b1;
                end else begin
                    bank_act_d[SDRAM_BA] = 1'b1;
                    row_d[SDRAM_BA]      = SDRAM_A;
                    cnt_d[SDRAM_BA]      = CNT_W'(TRCD_M1);
                end
            end
            CMD_RD: begin
                cancel    = 1'b1;
                gen_act_d = 1'b0;
                if (!acc_ok) begin
                    err = 1'b1;
                end else begin
                    p1_v_d     = 1'b1;
                    p1_addr_d  = acc_addr;
                    p1_cl3_d   = (cl_q == 3'd3);
                    gen_act_d  = (bl_mask != 3'd0);
                    gen_ba_d   = SDRAM_BA;
                    gen_row_d  = row_q[SDRAM_BA];
                    gen_col_d  = SDRAM_A[8:0];
                    gen_k_d    = 3'd1;
                    gen_mask_d = bl_mask;
                    gen_cl3_d  = (cl_q == 3'd3);
                    if (SDRAM_A[10]) bank_act_d[SDRAM_BA] = 1'b0;
                end
            end
            CMD_WR: begin
                cancel    = 1'b1;
                gen_act_d = 1'b0;
                if (!acc_ok) begin
                    err = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    err    = dq_oe_q;
                    if (SDRAM_A[10]) bank_act_d[SDRAM_BA] = 1'b0;
                end
            end
            CMD_BST: begin
                cancel    = 1'b1;
                gen_act_d = 1'b0;
            end
            CMD_PRE: begin
                if (SDRAM_A[10]) begin
                    bank_act_d = 4'b0000;
                    cancel     = 1'b1;
                end else begin
                    bank_act_d[SDRAM_BA] = 1'b0;
                    cancel               = (SDRAM_BA == gen_ba_q);
                end
                if (cancel) gen_act_d = 1'b0;
            end
            CMD_REF: begin
                err = (bank_act_q != 4'b0000);
            end
            CMD_LMR: begin
                if (bank_act_q != 4'b0000) begin
                    err = 1'b1;
                end else begin
                    cl_d         = SDRAM_A[6:4];
                    bl_d         = SDRAM_A[2:0];
                    mode_valid_d = mode_ok;
                    err          = !mode_ok;
                end
            end
            default: ;
        endcase

        // Remaining burst beats enter the CL pipeline one per cycle until cancelled.
        if (gen_act_q && !cancel) begin
            p1_v_d    = 1'b1;
            p1_addr_d = MEM_AW'({gen_ba_q, gen_row_q, beat_col(gen_col_q, gen_k_q, gen_mask_q)});
            p1_cl3_d  = gen_cl3_q;
            gen_k_d   = gen_k_q + 3'd1;
            if (gen_k_q == gen_mask_q) gen_act_d = 1'b0;
        end

        // Beats are fetched at the output stage, so same-edge writes are forwarded.
        out_v      = p2_v_q || (p1_v_q && !p1_cl3_q);
        out_addr   = p2_v_q ? p2_addr_q : p1_addr_q;
        fetch_data = (mem_we && (acc_addr == out_addr)) ? mem_wdata : mem_q[out_addr];

        dq_oe_d      = out_v;
        dq_out_d     = out_v ? fetch_data : dq_out_q;
        cmd_err_d    = err;
        err_sticky_d = err_sticky_q | err;
    end

    // Backing store has no reset; contents survive controller resets.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[acc_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_act_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            mode_valid_q <= 1'b0;
            cl_q         <= 3'd2;
            bl_q         <= 3'd0;
            gen_act_q    <= 1'b0;
            gen_ba_q     <= 2'd0;
            gen_row_q    <= '0;
            gen_col_q    <= '0;
            gen_k_q      <= '0;
            gen_mask_q   <= '0;
            gen_cl3_q    <= 1'b0;
            p1_v_q       <= 1'b0;
            p1_addr_q    <= '0;
            p1_cl3_q     <= 1'b0;
            p2_v_q       <= 1'b0;
            p2_addr_q    <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            cmd_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            bank_act_q   <= bank_act_d;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= row_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            mode_valid_q <= mode_valid_d;
            cl_q         <= cl_d;
            bl_q         <= bl_d;
            gen_act_q    <= gen_act_d;
            gen_ba_q     <= gen_ba_d;
            gen_row_q    <= gen_row_d;
            gen_col_q    <= gen_col_d;
            gen_k_q      <= gen_k_d;
            gen_mask_q   <= gen_mask_d;
            gen_cl3_q    <= gen_cl3_d;
            p1_v_q       <= p1_v_d;
            p1_addr_q    <= p1_addr_d;
            p1_cl3_q     <= p1_cl3_d;
            p2_v_q       <= p2_v_d;
            p2_addr_q    <= p2_addr_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            cmd_err_q    <= cmd_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;
    assign mode_valid = mode_valid_q;
    assign cmd_err    = cmd_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: commands are driven before each rising edge and
// outputs are checked 1 ns after it against hand-computed values.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        nCS, nRAS, nCAS, nWE;
    logic [12:0] A;
    logic [1:0]  BA;
    logic        DQML, DQMH;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        mode_valid;
    logic        cmd_err;
    logic        err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_responder #(.MEM_AW(12), .TRCD(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .SDRAM_nCS  (nCS),
        .SDRAM_nRAS (nRAS),
        .SDRAM_nCAS (nCAS),
        .SDRAM_nWE  (nWE),
        .SDRAM_A    (A),
        .SDRAM_BA   (BA),
        .SDRAM_DQML (DQML),
        .SDRAM_DQMH (DQMH),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .mode_valid (mode_valid),
        .cmd_err    (cmd_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for exactly one rising edge, then return to NOP.
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] dqm_hl);
        {nCS, nRAS, nCAS, nWE} = c;
        BA    = ba;
        A     = a;
        dq_in = d;
        {DQMH, DQML} = dqm_hl;
        @(posedge clk);
        #1;
        {nCS, nRAS, nCAS, nWE} = C_NOP;
    endtask

    logic [15:0] burst_exp [4];

    initial begin
        reset = 1'b1;
        {nCS, nRAS, nCAS, nWE} = C_NOP;
        A = '0; BA = '0; DQML = 1'b0; DQMH = 1'b0; dq_in = '0;
        nop(3);
        check("rst_dq_oe", 16'(dq_oe), 16'd0);
        check("rst_dq_out", dq_out, 16'h0000);
        check("rst_mode_valid", 16'(mode_valid), 16'd0);
        check("rst_cmd_err", 16'(cmd_err), 16'd0);
        check("rst_err_sticky", 16'(err_sticky), 16'd0);
        reset = 1'b0;
        nop(1);

        // Basic write/read, CL2 BL1
        issue(C_LMR, 2'd0, 13'h220, 16'h0, 2'b00);
        check("lmr220_valid", 16'(mode_valid), 16'd1);
        check("lmr220_err", 16'(cmd_err), 16'd0);
        issue(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        nop(2);
        issue(C_WR, 2'd1, 13'd3, 16'hBEEF, 2'b00);
        check("wr_beef_err", 16'(cmd_err), 16'd0);
        issue(C_RD, 2'd1, 13'd3, 16'h0, 2'b00);
        check("rd_t0_oe", 16'(dq_oe), 16'd0);
        nop(1);
        check("rd_beat_oe", 16'(dq_oe), 16'd1);
        check("rd_beat_data", dq_out, 16'hBEEF);
        nop(1);
        check("rd_after_oe", 16'(dq_oe), 16'd0);
        check("rd_after_hold", dq_out, 16'hBEEF);

        // Byte mask: high byte preserved
        issue(C_WR, 2'd1, 13'd8, 16'h1234, 2'b00);
        issue(C_WR, 2'd1, 13'd8, 16'hABCD, 2'b10);
        issue(C_RD, 2'd1, 13'd8, 16'h0, 2'b00);
        nop(1);
        check("dqm_oe", 16'(dq_oe), 16'd1);
        check("dqm_data", dq_out, 16'h12CD);
        nop(1);

        // Protocol violations
        issue(C_ACT, 2'd2, 13'd7, 16'h0, 2'b00);
        issue(C_RD, 2'd2, 13'd0, 16'h0, 2'b00);
        check("trcd_err", 16'(cmd_err), 16'd1);
        check("trcd_sticky", 16'(err_sticky), 16'd1);
        nop(1);
        check("err_pulse_clear", 16'(cmd_err), 16'd0);
        check("sticky_hold", 16'(err_sticky), 16'd1);
        check("trcd_no_read", 16'(dq_oe), 16'd0);
        issue(C_RD, 2'd3, 13'd0, 16'h0, 2'b00);
        check("rd_idle_err", 16'(cmd_err), 16'd1);
        issue(C_REF, 2'd0, 13'd0, 16'h0, 2'b00);
        check("ref_open_err", 16'(cmd_err), 16'd1);
        issue(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        check("pre_all_ok", 16'(cmd_err), 16'd0);
        issue(C_LMR, 2'd0, 13'h040, 16'h0, 2'b00);
        check("lmr040_err", 16'(cmd_err), 16'd1);
        check("lmr040_invalid", 16'(mode_valid), 16'd0);

        // Burst CL3 BL4 with wrap
        issue(C_LMR, 2'd0, 13'h232, 16'h0, 2'b00);
        check("lmr232_valid", 16'(mode_valid), 16'd1);
        issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b00);
        nop(2);
        for (int i = 0; i < 4; i++) begin
            issue(C_WR, 2'd0, 13'(4 + i), 16'(16'h10 + i), 2'b00);
        end
        burst_exp[0] = 16'h0012;
        burst_exp[1] = 16'h0013;
        burst_exp[2] = 16'h0010;
        burst_exp[3] = 16'h0011;
        issue(C_RD, 2'd0, 13'd6, 16'h0, 2'b00);
        nop(1);
        check("burst_lat_oe", 16'(dq_oe), 16'd0);
        for (int k = 0; k < 4; k++) begin
            nop(1);
            check($sformatf("burst_oe%0d", k), 16'(dq_oe), 16'd1);
            check($sformatf("burst_d%0d", k), dq_out, burst_exp[k]);
        end
        nop(1);
        check("burst_end_oe", 16'(dq_oe), 16'd0);

        // PRECHARGE all mid-burst: only beats already in the pipeline complete
        issue(C_RD, 2'd0, 13'd4, 16'h0, 2'b00);
        nop(1);
        issue(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        check("pre_b0_oe", 16'(dq_oe), 16'd1);
        check("pre_b0_d", dq_out, 16'h0010);
        nop(1);
        check("pre_b1_oe", 16'(dq_oe), 16'd1);
        check("pre_b1_d", dq_out, 16'h0011);
        nop(1);
        check("pre_cut_oe", 16'(dq_oe), 16'd0);
        nop(1);
        check("pre_cut_oe2", 16'(dq_oe), 16'd0);
        issue(C_RD, 2'd0, 13'd4, 16'h0, 2'b00);
        check("rd_after_pre_err", 16'(cmd_err), 16'd1);

        // Reset during a CL3 burst
        issue(C_ACT, 2'd0, 13'd0, 16'h0, 2'b00);
        nop(2);
        issue(C_RD, 2'd0, 13'd5, 16'h0, 2'b00);
        nop(2);
        check("prerst_oe", 16'(dq_oe), 16'd1);
        check("prerst_d", dq_out, 16'h0011);
        #2 reset = 1'b1;
        #1;
        check("midrst_oe", 16'(dq_oe), 16'd0);
        check("midrst_mode", 16'(mode_valid), 16'd0);
        check("midrst_sticky", 16'(err_sticky), 16'd0);
        nop(2);
        reset = 1'b0;
        issue(C_RD, 2'd0, 13'd5, 16'h0, 2'b00);
        check("rd_after_rst_err", 16'(cmd_err), 16'd1);
        nop(1);

        // CL2 BL2: store survives reset, write during bus drive flags contention
        issue(C_LMR, 2'd0, 13'h221, 16'h0, 2'b00);
        check("lmr221_valid", 16'(mode_valid), 16'd1);
        issue(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        nop(2);
        issue(C_WR, 2'd1, 13'd2, 16'h5555, 2'b00);
        issue(C_RD, 2'd1, 13'd2, 16'h0, 2'b00);
        nop(1);
        check("bl2_b0_oe", 16'(dq_oe), 16'd1);
        check("bl2_b0_d", dq_out, 16'h5555);
        issue(C_WR, 2'd1, 13'd9, 16'h7777, 2'b00);
        check("contention_err", 16'(cmd_err), 16'd1);
        check("bl2_b1_oe", 16'(dq_oe), 16'd1);
        check("bl2_b1_persist", dq_out, 16'hBEEF);
        nop(1);
        check("bl2_end_oe", 16'(dq_oe), 16'd0);
        issue(C_RD, 2'd1, 13'd8, 16'h0, 2'b00);
        nop(1);
        check("bl2b_b0_d", dq_out, 16'h12CD);
        nop(1);
        check("contention_wr_done", dq_out, 16'h7777);
        nop(1);
        check("bl2b_end_oe", 16'(dq_oe), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
